fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_if.sv | 31 +++
 rtl/fifo_uart_tx.sv | 117 +++++++++++
 tb/tb_fifo_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between a byte FIFO, the UART transmitter and whoever watches the serial line.
// The transmitter takes the slave view; the FIFO/line side takes the master view.
interface fifo_uart_tx_if;
   logic       enable;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   modport master (
      output enable,
      output fifo_empty,
      output fifo_rd_data,
      input  fifo_rd_en,
      input  tx,
      input  busy,
      input  tx_done
   );

   modport slave (
      input  enable,
      input  fifo_empty,
      input  fifo_rd_data,
      output fifo_rd_en,
      output tx,
      output busy,
      output tx_done
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pulls bytes from a FIFO with a one-cycle read latency.
// Frames are exactly 10*CLKS_PER_BIT cycles; back-to-back frames are separated by IDLE+FETCH.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input logic           clk,
   input logic           reset,
   fifo_uart_tx_if.slave bus
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

   state_t        state;
   state_t        state_next;
   logic [BW-1:0] baud;
   logic [BW-1:0] baud_next;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_next;
   logic [7:0]    shift_reg;
   logic [7:0]    shift_next;
   logic          tx_reg;
   logic          tx_next;
   logic          read_now;
   logic          done;
   logic          bit_end;
   logic          rd_strobe;

   assign bit_end = (baud == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         baud      <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state     <= state_next;
         baud      <= baud_next;
         bit_idx   <= bit_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
      end
   end

   always_comb begin
      state_next = state;
      baud_next  = baud;
      bit_next   = bit_idx;
      shift_next = shift_reg;
      read_now   = 1'b0;
      done       = 1'b0;
      tx_next    = 1'b1;
      case (state)
         IDLE: begin
            if (bus.enable && !bus.fifo_empty) begin
               read_now   = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: begin
            shift_next = bus.fifo_rd_data;
            baud_next  = '0;
            bit_next   = '0;
            state_next = START;
         end
         START: begin
            if (bit_end) begin
               baud_next  = '0;
               state_next = DATA;
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_next  = '0;
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_idx + 3'd1;
               end
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_next  = '0;
               done       = 1'b1;
               state_next = IDLE;
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // The line level is precomputed from the next state so tx comes straight off a flop.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   // Reset gates the read strobe so a held reset can never pop the FIFO.
   assign rd_strobe      = read_now & ~reset;
   assign bus.fifo_rd_en = rd_strobe;
   assign bus.busy       = (state != IDLE) | rd_strobe;
   assign bus.tx_done    = done;
   assign bus.tx         = tx_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: table of known frames, corner-case sequences,
// and random bytes recovered by an independent UART receiver model.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   typedef struct {
      logic [7:0] data;
      logic [0:9] line;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fifo_uart_tx_if bus ();

   fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail = 0;

   // Bench FIFO: data appears the cycle after a read strobe.
   logic [7:0] fifo_mem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic [7:0] exp_mem [64];
   int exp_cnt = 0;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
         bus.fifo_rd_data <= fifo_mem[rd_ptr % 256];
         rd_ptr <= rd_ptr + 1;
      end
   end

   int rd_count = 0;
   int done_count = 0;
   int empty_reads = 0;
   int reset_events = 0;

   always @(posedge clk) begin
      if (bus.fifo_rd_en) rd_count <= rd_count + 1;
      if (bus.fifo_rd_en && bus.fifo_empty) empty_reads <= empty_reads + 1;
      if (bus.tx_done) done_count <= done_count + 1;
   end

   always @(posedge reset) reset_events <= reset_events + 1;

   // Receiver model: find the start edge, sample each bit in its middle, drop frames cut by reset.
   logic [7:0] rx_mem [64];
   int rx_cnt = 0;
   int frame_err = 0;

   always begin : uart_rx
      logic [7:0] b;
      int ev;
      bit bad;
      @(negedge bus.tx);
      if (!reset) begin
         ev  = reset_events;
         bad = 1'b0;
         b   = 8'h00;
         repeat (CPB / 2) @(posedge clk);
         #1;
         if (bus.tx !== 1'b0) bad = 1'b1;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            b[i] = bus.tx;
         end
         repeat (CPB) @(posedge clk);
         #1;
         if (bus.tx !== 1'b1) bad = 1'b1;
         if (ev == reset_events) begin
            if (bad) begin
               frame_err = frame_err + 1;
            end else begin
               rx_mem[rx_cnt % 64] = b;
               rx_cnt = rx_cnt + 1;
            end
         end
      end
   end

   function automatic logic [0:9] make_line(input logic [7:0] b);
      logic [0:9] l;
      l[0] = 1'b0;
      for (int i = 0; i < 8; i++) l[i+1] = b[i];
      l[9] = 1'b1;
      return l;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks = n_checks + 1;
      if (actual !== expected) begin
         n_fail = n_fail + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit expect_rx);
      fifo_mem[wr_ptr % 256] = b;
      wr_ptr = wr_ptr + 1;
      if (expect_rx) begin
         exp_mem[exp_cnt % 64] = b;
         exp_cnt = exp_cnt + 1;
      end
   endtask

   task automatic waitRead(input string tag, output bit ok);
      ok = 1'b0;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (bus.fifo_rd_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput({tag, " read strobe"}, 32'(ok), 32'd1);
   endtask

   // Follows one frame cycle by cycle from its read strobe to the IDLE cycle after STOP.
   task automatic expectFrame(input logic [0:9] line, input int drop_at, input string tag, input bit next_pending);
      bit ok;
      waitRead(tag, ok);
      if (ok) begin
         checkOutput({tag, " busy on read"}, 32'(bus.busy), 32'd1);
         checkOutput({tag, " tx on read"}, 32'(bus.tx), 32'd1);
         @(posedge clk);
         #1;
         checkOutput({tag, " fetch rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
         checkOutput({tag, " fetch busy"}, 32'(bus.busy), 32'd1);
         checkOutput({tag, " fetch tx"}, 32'(bus.tx), 32'd1);
         for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (c == drop_at) bus.enable = 1'b0;
            checkOutput($sformatf("%s tx c%0d", tag, c), 32'(bus.tx), 32'(line[c / 4]));
            checkOutput($sformatf("%s tx_done c%0d", tag, c), 32'(bus.tx_done), 32'(c == 39));
            checkOutput($sformatf("%s busy c%0d", tag, c), 32'(bus.busy), 32'd1);
         end
         @(posedge clk);
         #1;
         checkOutput({tag, " gap tx"}, 32'(bus.tx), 32'd1);
         checkOutput({tag, " gap tx_done"}, 32'(bus.tx_done), 32'd0);
         checkOutput({tag, " gap rd_en"}, 32'(bus.fifo_rd_en), 32'(next_pending));
         checkOutput({tag, " gap busy"}, 32'(bus.busy), 32'(next_pending));
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got time limit, expected end of test");
      $fatal(1, "[TB] aborted");
   end

   initial begin : main
      vec_t vecs [7];
      logic [7:0] rnd [16];
      int rd_before;
      int done_before;
      int bad;
      bit ok;

      vecs[0] = '{8'hA5, 10'b0101001011};
      vecs[1] = '{8'h00, 10'b0000000001};
      vecs[2] = '{8'hFF, 10'b0111111111};
      vecs[3] = '{8'h3C, 10'b0001111001};
      vecs[4] = '{8'h01, 10'b0100000001};
      vecs[5] = '{8'h80, 10'b0000000011};
      vecs[6] = '{8'h5A, 10'b0010110101};

      bus.enable = 1'b0;
      #1;
      reset = 1'b1;
      bus.enable = 1'b1;
      applyStimulus(8'hC3, 1'b1);
      #2;
      checkOutput("reset rd_en", 32'(bus.fifo_rd_en), 32'd0);
      checkOutput("reset tx", 32'(bus.tx), 32'd1);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset tx_done", 32'(bus.tx_done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset held no read", 32'(rd_count), 32'd0);
      reset = 1'b0;
      expectFrame(make_line(8'hC3), -1, "post_reset", 1'b0);

      $display("[TB] table frames");
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].data, 1'b1);
         expectFrame(vecs[v].line, -1, $sformatf("vec%0d", v), 1'b0);
      end

      $display("[TB] back-to-back 00/FF");
      rd_before = rd_count;
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      expectFrame(10'b0000000001, -1, "b2b_first", 1'b1);
      expectFrame(10'b0111111111, -1, "b2b_second", 1'b0);
      checkOutput("b2b read count", 32'(rd_count - rd_before), 32'd2);

      $display("[TB] empty FIFO idle");
      rd_before = rd_count;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.fifo_rd_en !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) bad = bad + 1;
      end
      checkOutput("idle_empty bad cycles", 32'(bad), 32'd0);
      checkOutput("idle_empty reads", 32'(rd_count - rd_before), 32'd0);

      $display("[TB] enable dropped mid-frame");
      rd_before = rd_count;
      done_before = done_count;
      applyStimulus(8'h3C, 1'b1);
      applyStimulus(8'h11, 1'b1);
      expectFrame(10'b0001111001, 16, "en_drop", 1'b0);
      checkOutput("en_drop tx_done count", 32'(done_count - done_before), 32'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.fifo_rd_en !== 1'b0 || bus.busy !== 1'b0) bad = bad + 1;
      end
      checkOutput("en_drop held off cycles", 32'(bad), 32'd0);
      checkOutput("en_drop read count", 32'(rd_count - rd_before), 32'd1);
      bus.enable = 1'b1;
      expectFrame(make_line(8'h11), -1, "en_resume", 1'b0);

      $display("[TB] reset during DATA");
      applyStimulus(8'h55, 1'b0);
      rd_before = rd_count;
      done_before = done_count;
      waitRead("rst_frame", ok);
      repeat (11) @(posedge clk);
      #1;
      checkOutput("rst_frame tx before reset", 32'(bus.tx), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_frame tx", 32'(bus.tx), 32'd1);
      checkOutput("rst_frame busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_frame tx_done", 32'(bus.tx_done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk);
         #1;
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad = bad + 1;
      end
      checkOutput("rst_frame quiet cycles", 32'(bad), 32'd0);
      checkOutput("rst_frame tx_done count", 32'(done_count - done_before), 32'd0);
      checkOutput("rst_frame read count", 32'(rd_count - rd_before), 32'd1);
      applyStimulus(8'h96, 1'b1);
      expectFrame(make_line(8'h96), -1, "after_rst", 1'b0);

      $display("[TB] random burst");
      for (int k = 0; k < 16; k++) begin
         rnd[k] = 8'($urandom_range(0, 255));
         applyStimulus(rnd[k], 1'b1);
      end
      for (int k = 0; k < 16; k++) begin
         expectFrame(make_line(rnd[k]), -1, $sformatf("rand%0d", k), k < 15);
      end

      repeat (10) @(posedge clk);
      #1;
      checkOutput("scoreboard byte count", 32'(rx_cnt), 32'(exp_cnt));
      for (int i = 0; i < exp_cnt && i < rx_cnt; i++) begin
         checkOutput($sformatf("scoreboard byte %0d", i), 32'(rx_mem[i % 64]), 32'(exp_mem[i % 64]));
      end
      checkOutput("framing errors", 32'(frame_err), 32'd0);
      checkOutput("reads from empty FIFO", 32'(empty_reads), 32'd0);
      checkOutput("total reads", 32'(rd_count), 32'(wr_ptr));
      checkOutput("total tx_done", 32'(done_count), 32'(exp_cnt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
